// File: rtl/fixed_power.sv
// Iterative Q10.10 power unit: base^n via repeated 20-cycle shift-add multiplies,
// truncating each product and saturating to all-ones on integer overflow.
module fixed_power #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [EXP_W-1:0] in_data_2,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_base;
  logic [WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic [EXP_W-1:0]   r_rem;

  logic [2*WIDTH-1:0] w_sum;
  logic [WIDTH-1:0]   w_new_acc;
  logic               w_sat;
  logic               w_last_bit;

  assign w_sum      = r_prod + (r_base[r_cnt] ? ((2*WIDTH)'(r_acc) << r_cnt) : '0);
  assign w_new_acc  = w_sum[WIDTH+FRAC-1:FRAC];
  assign w_sat      = |w_sum[2*WIDTH-1:WIDTH+FRAC];
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_nxt = CALC;
      CALC: begin
        if (r_rem == '0)
          w_state_nxt = DONE;
        else if (w_last_bit && (w_sat || r_rem == EXP_W'(1)))
          w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_acc     <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_base <= in_data_1;
            r_rem  <= in_data_2;
            r_acc  <= ONE;
            r_prod <= '0;
            r_cnt  <= '0;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          if (r_rem == '0) begin
            out_data  <= ONE;
            out_valid <= 1'b1;
          end else if (w_last_bit) begin
            // Overflow ends the whole operation; later multiplies are skipped.
            if (w_sat) begin
              out_data  <= '1;
              out_ovf   <= 1'b1;
              out_valid <= 1'b1;
            end else if (r_rem == EXP_W'(1)) begin
              out_data  <= w_new_acc;
              out_valid <= 1'b1;
            end else begin
              r_acc  <= w_new_acc;
              r_prod <= '0;
              r_cnt  <= '0;
              r_rem  <= r_rem - EXP_W'(1);
            end
          end else begin
            r_prod <= w_sum;
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ovf   <= 1'b0;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_power.sv
// Scoreboard bench for fixed_power: driver queues hand-computed results,
// a negedge monitor pops and checks data, overflow, latency and busy.
module tb_fixed_power;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data_1 = '0;
  logic [2:0]  in_data_2 = '0;
  logic        busy, out_valid, out_ovf;
  logic [19:0] out_data;

  fixed_power #(.WIDTH(20), .FRAC(10), .EXP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] d;
    logic        ovf;
    int unsigned lat;
    int unsigned e0;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          tb_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !tb_done) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
          chk("latency", cyc - e.e0, e.lat);
          chk("busy_at_valid", 32'(busy), 32'd1);
        end
      end else begin
        chk("idle_outputs_zero", {out_data, 11'd0, out_ovf}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [19:0] base, input logic [2:0] n,
                       input logic [19:0] d, input logic ovf, input int unsigned lat,
                       input bit push, output int unsigned e0);
    int unsigned t = 0;
    exp_t e;
    @(negedge clk);
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("issue_wait_timeout", 32'(busy), 32'd0);
    in_valid  = 1'b1;
    in_data_1 = base;
    in_data_2 = n;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (push) begin
      e.d = d; e.ovf = ovf; e.lat = lat; e.e0 = e0;
      q.push_back(e);
    end
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || busy) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_valid(output int unsigned at);
    int unsigned t = 0;
    @(negedge clk);
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("wait_valid_timeout", 32'(out_valid), 32'd1);
    at = cyc;
  endtask

  initial begin
    int unsigned e0, e0b, vat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    repeat (200) @(negedge clk);

    issue(20'h00800, 3'd3, 20'h02000, 1'b0, 60, 1'b1, e0); drain();
    issue(20'h00600, 3'd2, 20'h00900, 1'b0, 40, 1'b1, e0); drain();
    issue(20'h005A8, 3'd2, 20'h007FF, 1'b0, 40, 1'b1, e0); drain();
    issue(20'h12345, 3'd1, 20'h12345, 1'b0, 20, 1'b1, e0); drain();
    issue(20'hABCDE, 3'd0, 20'h00400, 1'b0, 1, 1'b1, e0); drain();
    issue(20'h00000, 3'd5, 20'h00000, 1'b0, 100, 1'b1, e0); drain();
    issue(20'h08000, 3'd2, 20'hFFFFF, 1'b1, 40, 1'b1, e0); drain();
    issue(20'h08000, 3'd7, 20'hFFFFF, 1'b1, 40, 1'b1, e0); drain();

    // New operands presented mid-operation must not disturb the result
    issue(20'h00800, 3'd3, 20'h02000, 1'b0, 60, 1'b1, e0);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; in_data_1 = 20'h08000; in_data_2 = 3'd7;
    @(negedge clk);
    in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
    drain();

    // Back-to-back: second start lands on the first IDLE edge after DONE
    issue(20'h00600, 3'd2, 20'h00900, 1'b0, 40, 1'b1, e0);
    wait_valid(vat);
    issue(20'h00800, 3'd1, 20'h00800, 1'b0, 20, 1'b1, e0b);
    chk("b2b_accept_edge", e0b - vat, 32'd2);
    drain();

    // Abort by reset mid-CALC, then a clean operation
    issue(20'h00800, 3'd3, 20'h02000, 1'b0, 60, 1'b0, e0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (80) @(negedge clk);
    issue(20'h00600, 3'd2, 20'h00900, 1'b0, 40, 1'b1, e0); drain();

    chk("queue_empty", 32'(q.size()), 32'd0);
    tb_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
